// File: rtl/fpga_io_pkg.sv
// Shared register offsets, key/control types and the seven-segment glyph table
// for the board I/O controller.
package fpga_io_pkg;

    localparam logic [3:0] DISP_OFS   = 4'h0;
    localparam logic [3:0] CTRL_OFS   = 4'h4;
    localparam logic [3:0] KEY_OFS    = 4'h8;
    localparam logic [3:0] STATUS_OFS = 4'hC;

    typedef logic [4:0] key_code_t;

    typedef struct packed {
        logic dp_en;
        logic blank;
        logic raw;
    } ctrl_t;

    // Segment order {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg7_hex(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/pb_debounce.sv
// One pushbutton: two-flop synchroniser, stability counter and a registered
// press pulse on each accepted rising edge.
module pb_debounce #(
    parameter int DEBOUNCE = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pb_i,
    output logic press_o
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       level_q, level_d;
    logic       press_q, press_d;
    logic       armed_q, armed_d;
    logic [1:0] vld_q, vld_d;
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = pb_i;
        sync2_d = sync1_q;
        vld_d   = {vld_q[0], 1'b1};
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q + 4'd1 == 4'(DEBOUNCE)) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
        // A button held through reset must be seen released before it can press
        armed_d = armed_q | (vld_q[1] & ~sync2_q);
        press_d = level_d & ~level_q & armed_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            vld_q   <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            vld_q   <= vld_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/fpga_io_ctrl.sv
// Board I/O controller: debounced key FIFO, seven-segment display driver and
// a four-register MMIO window for the CPU.
module fpga_io_ctrl
    import fpga_io_pkg::*;
#(
    parameter int NUM_PB     = 21,
    parameter int NUM_DIGITS = 8,
    parameter int DEBOUNCE   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    hz100,
    input  logic                    reset,
    input  logic [NUM_PB-1:0]       pb,
    input  logic [3:0]              bus_addr,
    input  logic [31:0]             bus_wdata,
    input  logic                    bus_we,
    input  logic                    bus_re,
    output logic [31:0]             bus_rdata,
    output logic                    bus_ack,
    output logic [8*NUM_DIGITS-1:0] ss,
    output logic                    key_irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [NUM_PB-1:0] press;
    key_code_t         push_code;
    logic              push_any;

    for (genvar k = 0; k < NUM_PB; k++) begin : g_pb
        pb_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
            .clk    (hz100),
            .reset  (reset),
            .pb_i   (pb[k]),
            .press_o(press[k])
        );
    end

    // Highest pressed index wins; codes equal the button index
    always_comb begin
        push_code = '0;
        for (int k = 0; k < NUM_PB; k++) begin
            if (press[k]) push_code = key_code_t'(k);
        end
        push_any = |press;
    end

    key_code_t               mem_q [FIFO_DEPTH];
    key_code_t               mem_d [FIFO_DEPTH];
    logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic                    ovf_q, ovf_d;
    logic [31:0]             disp_q, disp_d;
    ctrl_t                   ctrl_q, ctrl_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    ack_q, ack_d;
    logic [8*NUM_DIGITS-1:0] ss_q, ss_d;

    logic [3:0]    addr_w;
    logic [PW-1:0] count;
    logic          empty, full, rd_only, pop;
    logic          unused_addr;

    assign addr_w      = {bus_addr[3:2], 2'b00};
    assign unused_addr = ^bus_addr[1:0];
    assign count       = wptr_q - rptr_q;
    assign empty       = (count == '0);
    assign full        = (count == PW'(FIFO_DEPTH));
    assign rd_only     = bus_re & ~bus_we;
    assign pop         = rd_only & (addr_w == KEY_OFS) & ~empty;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = pop ? rptr_q + PW'(1) : rptr_q;
        ovf_d  = ovf_q;
        disp_d = disp_q;
        ctrl_d = ctrl_q;
        if (push_any && (!full || pop)) begin
            mem_d[wptr_q[AW-1:0]] = push_code;
            wptr_d = wptr_q + PW'(1);
        end
        if (bus_we && addr_w == STATUS_OFS && bus_wdata[31]) ovf_d = 1'b0;
        if (push_any && full && !pop) ovf_d = 1'b1;
        if (bus_we && addr_w == DISP_OFS) disp_d = bus_wdata;
        if (bus_we && addr_w == CTRL_OFS) ctrl_d = ctrl_t'(bus_wdata[2:0]);
    end

    always_comb begin
        ack_d   = bus_we | bus_re;
        rdata_d = '0;
        if (rd_only) begin
            case (addr_w)
                DISP_OFS:   rdata_d = disp_q;
                CTRL_OFS:   rdata_d = {29'b0, ctrl_q};
                KEY_OFS:    rdata_d = empty ? '0 :
                                      {1'b1, 26'b0, mem_q[rptr_q[AW-1:0]]};
                STATUS_OFS: rdata_d = {ovf_q, 26'b0, 5'(count)};
                default:    rdata_d = '0;
            endcase
        end
    end

    always_comb begin
        ss_d = '0;
        if (!ctrl_q.blank) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (ctrl_q.raw) begin
                    if (i < 4) ss_d[8*i +: 8] = disp_q[8*(i%4) +: 8];
                end else begin
                    ss_d[8*i +: 8] = {(i == 0) & ctrl_q.dp_en,
                                      seg7_hex(disp_q[4*i +: 4])};
                end
            end
        end
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            ovf_q   <= 1'b0;
            disp_q  <= '0;
            ctrl_q  <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            ss_q    <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            ovf_q   <= ovf_d;
            disp_q  <= disp_d;
            ctrl_q  <= ctrl_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            ss_q    <= ss_d;
        end
    end

    assign bus_rdata = rdata_q;
    assign bus_ack   = ack_q;
    assign ss        = ss_q;
    assign key_irq   = ~empty;

endmodule
